// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared data-memory request type and port identifiers
package mem_pkg;

  localparam int DATA_MEM_WIDTH = 5;

  typedef struct packed {
    logic                      we;
    logic [DATA_MEM_WIDTH-1:0] addr;
    logic [31:0]               wdata;
  } mem_req_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-input round-robin picker with one-hot grant
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // On a tie, last_i=1 means port 1 won most recently, so port 0 goes next.
  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - shares the single-port data memory between CPU (A) and loader (B)
module data_mem_arbiter #(
  parameter int DATA_MEM_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      A_REQ,
  input  logic                      A_WE,
  input  logic [DATA_MEM_WIDTH-1:0] A_ADDR,
  input  logic [31:0]               A_WDATA,
  output logic                      A_GNT,
  output logic                      A_RVALID,
  output logic [31:0]               A_RDATA,
  input  logic                      B_REQ,
  input  logic                      B_WE,
  input  logic [DATA_MEM_WIDTH-1:0] B_ADDR,
  input  logic [31:0]               B_WDATA,
  output logic                      B_GNT,
  output logic                      B_RVALID,
  output logic [31:0]               B_RDATA,
  output logic [DATA_MEM_WIDTH-1:0] MEM_ADDR,
  output logic [31:0]               MEM_DIN,
  output logic                      MEM_WE,
  input  logic [31:0]               MEM_DOUT
);

  import mem_pkg::*;

  mem_req_t   a_req, b_req, sel_req;
  logic [1:0] req;
  logic [1:0] gnt_raw;
  logic [1:0] gnt;
  logic       last_b_q, last_b_d;
  logic       a_rvalid_q, a_rvalid_d;
  logic       b_rvalid_q, b_rvalid_d;

  assign req = {B_REQ, A_REQ};

  rr_pick2 u_pick (
    .req_i  (req),
    .last_i (last_b_q),
    .gnt_o  (gnt_raw)
  );

  assign gnt   = RST ? 2'b00 : gnt_raw;
  assign A_GNT = gnt[PORT_A];
  assign B_GNT = gnt[PORT_B];

  // The request struct is sized by the package default address width.
  assign a_req = '{we: A_WE, addr: A_ADDR, wdata: A_WDATA};
  assign b_req = '{we: B_WE, addr: B_ADDR, wdata: B_WDATA};

  // With no grant the mux rests on port A, keeping MEM_ADDR on A_ADDR.
  assign sel_req  = gnt[PORT_B] ? b_req : a_req;
  assign MEM_ADDR = sel_req.addr;
  assign MEM_DIN  = sel_req.wdata;
  assign MEM_WE   = (|gnt) & sel_req.we;

  always_comb begin
    last_b_d   = last_b_q;
    a_rvalid_d = gnt[PORT_A] & ~A_WE;
    b_rvalid_d = gnt[PORT_B] & ~B_WE;
    if (|gnt) begin
      last_b_d = gnt[PORT_B];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_b_q   <= 1'b1;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      last_b_q   <= last_b_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  // A read granted just before reset must not report data during reset.
  assign A_RVALID = a_rvalid_q & ~RST;
  assign B_RVALID = b_rvalid_q & ~RST;
  assign A_RDATA  = MEM_DOUT;
  assign B_RDATA  = MEM_DOUT;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter with a reference memory model
module tb_data_mem_arbiter;

  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          A_REQ = 1'b0, A_WE = 1'b0;
  logic [AW-1:0] A_ADDR = '0;
  logic [31:0]   A_WDATA = '0;
  logic          B_REQ = 1'b0, B_WE = 1'b0;
  logic [AW-1:0] B_ADDR = '0;
  logic [31:0]   B_WDATA = '0;
  logic          A_GNT, A_RVALID, B_GNT, B_RVALID;
  logic [31:0]   A_RDATA, B_RDATA;
  logic [AW-1:0] MEM_ADDR;
  logic [31:0]   MEM_DIN;
  logic          MEM_WE;
  logic [31:0]   MEM_DOUT;

  always #5 CLK = ~CLK;

  data_mem_arbiter #(.DATA_MEM_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
    .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_RDATA(A_RDATA),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
    .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_RDATA(B_RDATA),
    .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN), .MEM_WE(MEM_WE), .MEM_DOUT(MEM_DOUT)
  );

  // Physical memory attached to the arbiter, and the bench's own view of its contents.
  logic [31:0] bram    [0:31];
  logic [31:0] ref_mem [0:31];

  always @(posedge CLK) begin
    if (MEM_WE) bram[MEM_ADDR] <= MEM_DIN;
    MEM_DOUT <= bram[MEM_ADDR];
  end

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   na = 0, nb = 0;
  bit   model_last = 1'b1;

  always @(posedge CLK) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: read responses must appear exactly on the cycle the model scheduled them.
  always @(negedge CLK) begin
    logic ea, eb;
    ea = (qa.size() > 0) && (qa[0].due == cyc);
    eb = (qb.size() > 0) && (qb[0].due == cyc);
    chk("A_RVALID", {31'd0, A_RVALID}, {31'd0, ea});
    chk("B_RVALID", {31'd0, B_RVALID}, {31'd0, eb});
    if (ea) begin
      if (A_RVALID) chk("A_RDATA", A_RDATA, qa[0].data);
      void'(qa.pop_front());
    end
    if (eb) begin
      if (B_RVALID) chk("B_RDATA", B_RDATA, qb[0].data);
      void'(qb.pop_front());
    end
  end

  task automatic rand_a();
    A_REQ = 1'b1; A_WE = 1'($urandom_range(0, 1));
    A_ADDR = AW'($urandom_range(0, 31)); A_WDATA = $urandom;
  endtask

  task automatic rand_b();
    B_REQ = 1'b1; B_WE = 1'($urandom_range(0, 1));
    B_ADDR = AW'($urandom_range(0, 31)); B_WDATA = $urandom;
  endtask

  // One cycle: predict the grant from the arbitration rules, check, update the model.
  task automatic step(input bit auto_a, input bit auto_b);
    bit pa, pb, ga, gb;
    @(negedge CLK);
    pa = A_REQ && !RST;
    pb = B_REQ && !RST;
    ga = pa && (!pb || model_last);
    gb = pb && (!pa || !model_last);
    chk("A_GNT", {31'd0, A_GNT}, {31'd0, ga});
    chk("B_GNT", {31'd0, B_GNT}, {31'd0, gb});
    chk("MEM_WE", {31'd0, MEM_WE}, {31'd0, (ga & A_WE) | (gb & B_WE)});
    if (!ga && !gb) chk("MEM_ADDR idle", {27'd0, MEM_ADDR}, {27'd0, A_ADDR});
    if (ga) begin
      chk("MEM_ADDR A", {27'd0, MEM_ADDR}, {27'd0, A_ADDR});
      if (A_WE) begin
        chk("MEM_DIN A", MEM_DIN, A_WDATA);
        ref_mem[A_ADDR] = A_WDATA;
      end else begin
        qa.push_back('{due: cyc + 1, data: ref_mem[A_ADDR]});
      end
      na++;
    end
    if (gb) begin
      chk("MEM_ADDR B", {27'd0, MEM_ADDR}, {27'd0, B_ADDR});
      if (B_WE) begin
        chk("MEM_DIN B", MEM_DIN, B_WDATA);
        ref_mem[B_ADDR] = B_WDATA;
      end else begin
        qb.push_back('{due: cyc + 1, data: ref_mem[B_ADDR]});
      end
      nb++;
    end
    if (RST) model_last = 1'b1;
    else if (ga || gb) model_last = gb;
    @(posedge CLK);
    #1;
    if (ga) begin
      if (auto_a) rand_a(); else A_REQ = 1'b0;
    end
    if (gb) begin
      if (auto_b) rand_b(); else B_REQ = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((A_REQ || B_REQ) && n < 20) begin
      step(1'b0, 1'b0);
      n++;
    end
    if (A_REQ || B_REQ) begin
      checks++;
      errors++;
      $display("FAIL grant timeout cycle %0d: got no grant within 20 cycles, required a grant", cyc);
      A_REQ = 1'b0;
      B_REQ = 1'b0;
    end
    step(1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    qa.delete();
    qb.delete();
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    RST = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      logic [31:0] v;
      v = $urandom;
      bram[i] = v;
      ref_mem[i] = v;
    end
    bram[3] = 32'hDEADBEEF;
    ref_mem[3] = 32'hDEADBEEF;

    // Reset with both ports requesting: no grants may leak out.
    @(posedge CLK);
    #1;
    A_REQ = 1'b1; B_REQ = 1'b1; A_WE = 1'b1; B_WE = 1'b1;
    do_reset(3);
    A_REQ = 1'b0; B_REQ = 1'b0;
    step(1'b0, 1'b0);

    // A alone reads addr 3.
    A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 5'd3;
    drain();

    // Tie right after reset: A first, then B's write, then A reads it back.
    do_reset(1);
    A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 5'd1;
    B_REQ = 1'b1; B_WE = 1'b1; B_ADDR = 5'd2; B_WDATA = 32'h12345678;
    drain();
    A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 5'd2;
    drain();

    // Continuous contention for 8 cycles.
    rand_a();
    rand_b();
    na = 0;
    nb = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
    chk("contention A grants", na, 4);
    chk("contention B grants", nb, 4);
    drain();

    // B writes addr 5, A reads it on the very next cycle.
    B_REQ = 1'b1; B_WE = 1'b1; B_ADDR = 5'd5; B_WDATA = 32'hCAFEF00D;
    step(1'b0, 1'b0);
    A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 5'd5;
    drain();

    // Read granted, reset on the next edge: its RVALID must never show.
    A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 5'd7;
    step(1'b0, 1'b0);
    do_reset(2);
    rand_a();
    rand_b();
    drain();

    // Idle cycles, then a tie to confirm the round-robin state held.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    rand_a();
    rand_b();
    drain();

    // Random traffic with back-to-back requests.
    for (int i = 0; i < 400; i++) begin
      if (!A_REQ && ($urandom_range(0, 1) == 1)) rand_a();
      if (!B_REQ && ($urandom_range(0, 1) == 1)) rand_b();
      step(1'b0, 1'b0);
    end
    drain();
    step(1'b0, 1'b0);
    chk("A responses outstanding", qa.size(), 0);
    chk("B responses outstanding", qb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
